cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL provide parameter BLOCK_WORDS, default 8, meaning 16-bit words per cache block (16 bytes).
REQ-002 The block SHALL provide parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 The block SHALL provide port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 The block SHALL provide port miss_detected  input  1  meaning cache lookup missed this cycle.
REQ-006 The block SHALL provide port miss_address  input  ADDR_W  meaning byte address that missed.
REQ-007 The block SHALL provide port memory_data  input  16  meaning word returned by main memory.
REQ-008 The block SHALL provide port memory_data_valid  input  1  meaning memory_data is valid this cycle.
REQ-009 The block SHALL provide port fsm_busy  output  1  meaning a fill is in progress; fetch/memory stage stalls.
REQ-010 The block SHALL provide port mem_read  output  1  meaning memory read request issued this cycle.
REQ-011 The block SHALL provide port memory_address  output  ADDR_W  meaning byte address of the current request.
REQ-012 The block SHALL provide port write_data_array  output  1  meaning write memory_data into the data array this cycle.
REQ-013 The block SHALL provide port word_sel  output  3  meaning word index within the block for the data-array write.
REQ-014 The block SHALL provide port write_tag_array  output  1  meaning write tag and set valid for the block this cycle.

Function
REQ-015 The block SHALL implement two states: IDLE and FILL.
REQ-016 In IDLE, when miss_detected=1 at a clock edge, the block SHALL enter FILL, latch base = miss_address with bits [3:0] cleared, and clear the issue and receive counters.
REQ-017 In FILL, fsm_busy SHALL be 1; in IDLE, fsm_busy SHALL be 0, so it is registered and rises one cycle after miss_detected.
REQ-018 In FILL, while issue_cnt < BLOCK_WORDS, mem_read SHALL be 1, memory_address SHALL equal base + 2*issue_cnt, and issue_cnt SHALL increment each cycle.
REQ-019 Requests SHALL issue one per cycle on 8 consecutive cycles; mem_read SHALL be 0 after the 8th request and in IDLE.
REQ-020 memory_address SHALL hold the last driven value when mem_read=0.
REQ-021 In FILL, write_data_array SHALL equal memory_data_valid, word_sel SHALL equal recv_cnt, and recv_cnt SHALL increment on each valid word.
REQ-022 On the valid word with recv_cnt=7, write_tag_array SHALL be 1 for exactly that cycle, and the state SHALL return to IDLE at the next edge.
REQ-023 memory_data_valid in IDLE SHALL be ignored: no writes and no counter change.
REQ-024 miss_detected during FILL SHALL be ignored; base SHALL NOT change.
REQ-025 The block SHALL tolerate any fixed memory latency of 1 or more cycles, including valid words arriving while requests are still being issued.
REQ-026 Counters SHALL be 4 bits wide so that the value 8 is representable, and SHALL NOT wrap within a fill.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; a block at 0xFFF0 SHALL issue 0xFFF0 through 0xFFFE.
REQ-028 A miss asserted on the same cycle that write_tag_array=1 SHALL be ignored, because the state is still FILL; the requester re-asserts the miss after the stall.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, with base, issue_cnt, recv_cnt and memory_address all at 0.
REQ-030 During reset, every output SHALL be 0.
REQ-031 Reset asserted mid-fill SHALL abandon the fill with no tag write; words returning after reset SHALL be ignored as IDLE data.

Structure
REQ-032 A shared package cache_pkg SHALL hold BLOCK_WORDS, the words-per-block log2 value (3), the offset width (4), and the IDLE/FILL state encoding.
REQ-033 One sub-module, fill_counter, SHALL be used twice (issue and receive): a 4-bit counter with clear, enable and async reset.
REQ-034 All registers SHALL use clk and async rst only; there SHALL be no other clock or latch.

Verification
REQ-035 Verification SHALL cover a fill with a 4-cycle-latency memory model: miss at 0x1234 -> mem_read on 8 cycles at 0x1230, 0x1232 ... 0x123E; write_data_array on 8 cycles with word_sel 0..7; write_tag_array once with word_sel=7; fsm_busy high for 12 cycles.
REQ-036 Verification SHALL cover wrap-around: miss at 0xFFFF -> addresses 0xFFF0 through 0xFFFE, with no carry into a 17th bit.
REQ-037 Verification SHALL cover a spurious miss: miss_detected pulsed at 0x4000 during a 0x1230 fill -> base stays 0x1230 and no second fill starts.
REQ-038 Verification SHALL cover a stray valid: memory_data_valid=1 while IDLE -> write_data_array=0, write_tag_array=0, counters unchanged.
REQ-039 Verification SHALL cover reset mid-fill: rst asserted after 3 words received -> all outputs 0 immediately, no tag write, and the next miss at 0x2000 completes a clean 8-word fill.
REQ-040 Verification SHALL cover back-to-back misses: miss re-asserted the cycle after fsm_busy falls -> the second fill starts with counters at 0 and issues address base+0 first.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants for the cache block-fill controller.
//   BLOCK_WORDS : 16-bit words per cache block (16 bytes)
//   WORDS_LOG2  : log2(BLOCK_WORDS), width of the word index
//   OFFSET_W    : byte-offset bits inside a block
//   CNT_W       : fill counter width; one wider than WORDS_LOG2 so that
//                 the terminal count BLOCK_WORDS is representable
//   ST_IDLE / ST_FILL : controller state encoding
// ---------------------------------------------------------------------------
package cache_pkg;
    localparam int BLOCK_WORDS = 8;
    localparam int WORDS_LOG2  = 3;
    localparam int OFFSET_W    = 4;
    localparam int CNT_W       = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;
endpackage

// File: rtl/fill_counter.sv
// ---------------------------------------------------------------------------
// fill_counter
// Small up-counter used for both the request-issue and word-receive counts
// of a block fill. Clear has priority over enable.
// Ports:
//   clk   : clock, counts on rising edge
//   rst   : asynchronous active-high reset, forces count to 0
//   clr   : synchronous clear to 0
//   en    : increment by one
//   cnt_q : current count
// ---------------------------------------------------------------------------
module fill_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_q
);

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Block-fill controller for a direct cache. On a miss it issues one memory
// read per cycle for every word of the block, writes each returned word into
// the data array and, on the last word, writes the tag/valid entry.
// Ports:
//   clk               : clock
//   rst               : asynchronous active-high reset
//   miss_detected     : lookup missed this cycle (only honoured in IDLE)
//   miss_address      : byte address that missed
//   memory_data       : word from main memory (data path is external)
//   memory_data_valid : memory_data valid this cycle
//   fsm_busy          : a fill is in progress; pipeline stalls
//   mem_read          : memory read request this cycle
//   memory_address    : byte address of the request; holds when idle
//   write_data_array  : write memory_data into the data array
//   word_sel          : word index for the data-array write
//   write_tag_array   : write tag and set valid for the block
//   state_dbg         : current controller state (debug visibility)
//
// Handshake: there is no back-pressure. A request is issued on every cycle
// mem_read=1, and a word is consumed on every cycle memory_data_valid=1
// while the controller is in FILL; anything else is ignored.
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int ADDR_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_detected,
    input  logic [ADDR_W-1:0]                 miss_address,
    input  logic [15:0]                       memory_data,
    input  logic                              memory_data_valid,
    output logic                              fsm_busy,
    output logic                              mem_read,
    output logic [ADDR_W-1:0]                 memory_address,
    output logic                              write_data_array,
    output logic [cache_pkg::WORDS_LOG2-1:0]  word_sel,
    output logic                              write_tag_array,
    output logic [0:0]                        state_dbg
);

    import cache_pkg::*;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  recv_cnt_q;

    logic              in_fill;
    logic              start_fill;
    logic              issue_en;
    logic              recv_en;
    logic              last_word;
    logic [ADDR_W-1:0] req_addr;

    // The returned word goes straight to the data array; this block only
    // steers the write strobes, so the data bits are intentionally unused.
    logic data_unused;
    assign data_unused = ^memory_data;

    assign in_fill    = (state_q == ST_FILL);
    assign start_fill = !in_fill && miss_detected;
    assign issue_en   = in_fill && (issue_cnt_q < CNT_W'(BLOCK_WORDS));
    // The count guard keeps the receive counter from ever wrapping in a fill.
    assign recv_en    = in_fill && memory_data_valid &&
                        (recv_cnt_q < CNT_W'(BLOCK_WORDS));
    assign last_word  = recv_en && (recv_cnt_q == CNT_W'(BLOCK_WORDS - 1));

    // Word offset in bytes is 2*issue_cnt; the sum wraps modulo 2^ADDR_W.
    assign req_addr   = base_q + ADDR_W'({issue_cnt_q, 1'b0});

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_addr_d = last_addr_q;

        if (start_fill) begin
            state_d = ST_FILL;
            base_d  = miss_address & ~ADDR_W'((1 << OFFSET_W) - 1);
        end else if (last_word) begin
            state_d = ST_IDLE;
        end

        if (issue_en) begin
            last_addr_d = req_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            last_addr_q <= last_addr_d;
        end
    end

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_fill),
        .en    (issue_en),
        .cnt_q (issue_cnt_q)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_fill),
        .en    (recv_en),
        .cnt_q (recv_cnt_q)
    );

    assign fsm_busy         = in_fill;
    assign mem_read         = issue_en;
    // Live request address while issuing, otherwise the last one driven.
    assign memory_address   = issue_en ? req_addr : last_addr_q;
    assign write_data_array = in_fill && memory_data_valid;
    assign word_sel         = in_fill ? recv_cnt_q[WORDS_LOG2-1:0] : '0;
    assign write_tag_array  = last_word;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_fsm
// Self-checking bench for cache_fill_fsm: a hand-computed vector table for
// the reference 4-cycle-latency fill, directed corner sequences, then random
// fills checked against a fill-schedule reference model.
// ---------------------------------------------------------------------------
module tb_cache_fill_fsm;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_sel;
    logic        write_tag_array;
    logic [0:0]  state_dbg;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_sel          (word_sel),
        .write_tag_array   (write_tag_array),
        .state_dbg         (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A fill accepted on cycle c runs from cycle c+1 (j=0). Request k goes
    // out at j=k, its word returns at j=k+lat, the tag write is at j=lat+7,
    // and the fill lasts lat+8 cycles.
    int          cyc         = 0;
    bit          m_active    = 0;
    int          m_start     = 0;
    int          m_lat       = 1;
    logic [15:0] m_base      = '0;
    logic [15:0] m_last_addr = '0;
    int          next_lat    = 4;

    task automatic cycle(input logic miss, input logic [15:0] addr,
                         input logic stray);
        int          j;
        logic        vld;
        logic        e_rd, e_wr, e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_sel;
        j   = cyc - m_start;
        vld = m_active ? (j >= m_lat && j < m_lat + 8) : stray;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = vld;
        memory_data       = 16'($urandom);

        e_rd   = m_active && (j < 8);
        e_addr = e_rd ? (m_base + 16'(2 * j)) : m_last_addr;
        e_wr   = m_active && vld;
        e_tag  = m_active && (j == m_lat + 7);
        e_sel  = (m_active && j >= m_lat) ? 3'(j - m_lat) : 3'd0;

        @(negedge clk);
        check("fsm_busy", fsm_busy, m_active);
        check("mem_read", mem_read, e_rd);
        check("memory_address", memory_address, e_addr);
        check("write_data_array", write_data_array, e_wr);
        check("write_tag_array", write_tag_array, e_tag);
        if (m_active) check("word_sel", word_sel, e_sel);

        @(posedge clk);
        if (e_rd) m_last_addr = e_addr;
        if (m_active && e_tag) begin
            m_active = 0;
        end else if (!m_active && miss) begin
            m_active = 1;
            m_base   = addr & 16'hFFF0;
            m_start  = cyc + 1;
            m_lat    = next_lat;
        end
        cyc++;
        #1;
    endtask

    task automatic run_to_idle();
        while (m_active) cycle(1'b0, 16'h0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        vld;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wr;
        logic [2:0]  sel;
        logic        tag;
    } vec_t;

    vec_t tbl[14];

    // Global time bound so the bench always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_busy, n_rd, n_tag, gap;

        // Miss at 0x1234, memory latency 4.
        tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd4, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd5, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd6, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd7, 1'b1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h123E, 1'b0, 3'd0, 1'b0};

        // ---- reset state ----
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = '0;
        memory_data = '0;
        memory_data_valid = 1'b0;
        #2;
        check("rst_busy", fsm_busy, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_addr", memory_address, 16'h0);
        check("rst_wr", write_data_array, 1'b0);
        check("rst_sel", word_sel, 3'd0);
        check("rst_tag", write_tag_array, 1'b0);
        check("rst_state", state_dbg, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table: reference fill ----
        n_busy = 0; n_rd = 0; n_tag = 0;
        for (int i = 0; i < 14; i++) begin
            miss_detected     = tbl[i].miss;
            miss_address      = tbl[i].addr;
            memory_data_valid = tbl[i].vld;
            memory_data       = 16'($urandom);
            @(negedge clk);
            check("tbl_busy", fsm_busy, tbl[i].busy);
            check("tbl_rd", mem_read, tbl[i].rd);
            check("tbl_addr", memory_address, tbl[i].maddr);
            check("tbl_wr", write_data_array, tbl[i].wr);
            check("tbl_tag", write_tag_array, tbl[i].tag);
            if (tbl[i].wr) check("tbl_sel", word_sel, tbl[i].sel);
            n_busy += int'(fsm_busy);
            n_rd   += int'(mem_read);
            n_tag  += int'(write_tag_array);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_cycles", 16'(n_busy), 16'd12);
        check("read_cycles", 16'(n_rd), 16'd8);
        check("tag_writes", 16'(n_tag), 16'd1);
        m_active    = 0;
        m_last_addr = 16'h123E;

        // ---- wrap-around at top of address space ----
        next_lat = 3;
        cycle(1'b1, 16'hFFFF, 1'b0);
        run_to_idle();

        // ---- spurious misses during a fill and on the tag cycle ----
        next_lat = 3;
        cycle(1'b1, 16'h1230, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 16'h4000, 1'b0);
        while (m_active) cycle((cyc - m_start) == m_lat + 7, 16'h4000, 1'b0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b0);

        // ---- stray valids while idle ----
        repeat (4) cycle(1'b0, 16'h0000, 1'b1);
        next_lat = 2;
        cycle(1'b1, 16'h0456, 1'b1);
        run_to_idle();

        // ---- reset mid-fill after 3 words ----
        next_lat = 2;
        cycle(1'b1, 16'h5678, 1'b0);
        repeat (m_lat + 3) cycle(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        memory_data_valid = 1'b1;
        miss_detected = 1'b0;
        #1;
        check("midrst_busy", fsm_busy, 1'b0);
        check("midrst_mem_read", mem_read, 1'b0);
        check("midrst_addr", memory_address, 16'h0);
        check("midrst_wr", write_data_array, 1'b0);
        check("midrst_sel", word_sel, 3'd0);
        check("midrst_tag", write_tag_array, 1'b0);
        check("midrst_state", state_dbg, 1'b0);
        @(negedge clk);
        check("midrst_tag_hold", write_tag_array, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        m_active    = 0;
        m_last_addr = 16'h0;
        repeat (4) cycle(1'b0, 16'h0000, 1'b1);
        next_lat = 4;
        cycle(1'b1, 16'h2000, 1'b0);
        run_to_idle();

        // ---- back-to-back misses ----
        next_lat = 5;
        cycle(1'b1, 16'hABCD, 1'b0);
        run_to_idle();
        next_lat = 1;
        cycle(1'b1, 16'h0102, 1'b0);
        run_to_idle();

        // ---- random fills ----
        for (int f = 0; f < 25; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                cycle(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
            next_lat = $urandom_range(1, 6);
            cycle(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
            while (m_active)
                cycle($urandom_range(0, 3) == 0, 16'($urandom), 1'b0);
        end
        repeat (2) cycle(1'b0, 16'h0000, 1'b0);

        // ---- final report ----
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
